// File: rtl/uart_sort_buffer.sv
// Batch sort stage between UART RX and TX: collects DEPTH bytes, bubble-sorts them
// one compare per cycle, then streams them out. Define SORT_DESCEND_EN for descending order.
module uart_sort_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_Clock,
    input  logic             i_Rst_n,
    input  logic             i_Rx_DV,
    input  logic [WIDTH-1:0] i_Rx_Byte,
    output logic             o_Tx_DV,
    output logic [WIDTH-1:0] o_Tx_Byte,
    input  logic             i_Tx_Done,
    output logic             o_Busy,
    output logic             o_Overrun
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_OUTER = IDX_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_COLLECT   = 2'd0,
        ST_SORT      = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    function automatic logic need_swap(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SORT_DESCEND_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic             tx_dv_q, tx_dv_d;
    logic [WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    logic [IDX_W-1:0] j_p1_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign j_p1_s    = j_q + IDX_W'(1);
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Next-state logic for the FSM, storage, counters and registered outputs.
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_COLLECT: begin
                if (i_Rx_DV) begin
                    mem_d[wr_idx_q] = i_Rx_Byte;
                    if (cnt_inc_s == FULL_CNT) begin
                        state_d  = ST_SORT;
                        wr_idx_d = {IDX_W{1'b0}};
                        cnt_d    = cnt_inc_s;
                        i_d      = {IDX_W{1'b0}};
                        j_d      = {IDX_W{1'b0}};
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                        cnt_d    = cnt_inc_s;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_SORT: begin
                if (need_swap(mem_q[j_q], mem_q[j_p1_s])) begin
                    mem_d[j_q]    = mem_q[j_p1_s];
                    mem_d[j_p1_s] = mem_q[j_q];
                end else begin
                    mem_d = mem_q;
                end
                // Inner pass shrinks by one each outer iteration; the largest settles at the top.
                if (j_q == LAST_OUTER - i_q) begin
                    j_d = {IDX_W{1'b0}};
                    if (i_q == LAST_OUTER) begin
                        state_d  = ST_SEND;
                        rd_idx_d = {IDX_W{1'b0}};
                        i_d      = {IDX_W{1'b0}};
                    end else begin
                        i_d = i_q + IDX_W'(1);
                    end
                end else begin
                    j_d = j_p1_s;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = ST_COLLECT;
                        cnt_d    = {CNT_W{1'b0}};
                        rd_idx_d = {IDX_W{1'b0}};
                    end else begin
                        state_d  = ST_SEND;
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        if (i_Rx_DV && (state_q != ST_COLLECT)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // Outputs are registered from the next state so they line up with the state itself.
        tx_dv_d = (state_d == ST_SEND);
        busy_d  = (state_d != ST_COLLECT);
        if (state_d == ST_SEND) begin
            tx_byte_d = mem_d[rd_idx_d];
        end else begin
            tx_byte_d = tx_byte_q;
        end
    end

    // State, storage and output registers with asynchronous reset.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_COLLECT;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {WIDTH{1'b0}};
            end
            wr_idx_q  <= {IDX_W{1'b0}};
            rd_idx_q  <= {IDX_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            i_q       <= {IDX_W{1'b0}};
            j_q       <= {IDX_W{1'b0}};
            tx_dv_q   <= 1'b0;
            tx_byte_q <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_Tx_DV   = tx_dv_q;
    assign o_Tx_Byte = tx_byte_q;
    assign o_Busy    = busy_q;
    assign o_Overrun = overrun_q;

endmodule

// File: tb/tb_uart_sort_buffer.sv
// Directed bench for uart_sort_buffer: table of batches plus hand-written corner sequences.
// Expected orders follow SORT_DESCEND_EN when that macro is defined.
module tb_uart_sort_buffer;

    logic       i_Clock = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_Rx_DV = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Done = 1'b0;
    logic       o_Busy;
    logic       o_Overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0][7:0] rx;
        logic [7:0][7:0] exp;
        int              dly;
    } vec_t;

    vec_t vecs[5];

    uart_sort_buffer #(.DEPTH(8), .WIDTH(8)) dut (
        .i_Clock   (i_Clock),
        .i_Rst_n   (i_Rst_n),
        .i_Rx_DV   (i_Rx_DV),
        .i_Rx_Byte (i_Rx_Byte),
        .o_Tx_DV   (o_Tx_DV),
        .o_Tx_Byte (o_Tx_Byte),
        .i_Tx_Done (i_Tx_Done),
        .o_Busy    (o_Busy),
        .o_Overrun (o_Overrun)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Elements are written first-to-last in the literal, so element k sits at index 7-k.
    task automatic send_batch(input logic [7:0][7:0] rx);
        for (int k = 0; k < 8; k++) begin
            i_Rx_DV   = 1'b1;
            i_Rx_Byte = rx[7-k];
            @(negedge i_Clock);
        end
        i_Rx_DV = 1'b0;
        chk("busy at N+1", 32'(o_Busy), 32'd1);
    endtask

    task automatic wait_first_dv(input int start);
        int lat;
        lat = start;
        while (o_Tx_DV !== 1'b1 && lat < 200) begin
            @(negedge i_Clock);
            lat++;
        end
        chk("first dv latency", 32'(lat), 32'd29);
    endtask

    task automatic drain(input logic [7:0][7:0] exp, input int n, input int dly);
        logic ok;
        int   w;
        for (int k = 0; k < n; k++) begin
            chk("tx byte", 32'(o_Tx_Byte), 32'(exp[7-k]));
            ok = 1'b1;
            for (int d = 0; d < dly; d++) begin
                @(negedge i_Clock);
                if (o_Tx_DV !== 1'b0 || o_Tx_Byte !== exp[7-k]) ok = 1'b0;
            end
            chk("single dv, byte held", 32'(ok), 32'd1);
            i_Tx_Done = 1'b1;
            @(negedge i_Clock);
            i_Tx_Done = 1'b0;
            if (k < 7) begin
                w = 1;
                while (o_Tx_DV !== 1'b1 && w < 6) begin
                    @(negedge i_Clock);
                    w++;
                end
                chk("done to next dv", 32'(w <= 2), 32'd1);
            end else begin
                chk("busy falls after last done", 32'(o_Busy), 32'd0);
            end
        end
    endtask

    initial begin
        vecs[0].rx = {8'h50, 8'h10, 8'h80, 8'h00, 8'hFF, 8'h7F, 8'h10, 8'h01};
        vecs[1].rx = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[2].rx = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        vecs[3].rx = {8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
        vecs[4].rx = {8'hFE, 8'h02, 8'hFE, 8'h02, 8'h00, 8'hFF, 8'h80, 8'h81};
`ifdef SORT_DESCEND_EN
        vecs[0].exp = {8'hFF, 8'h80, 8'h7F, 8'h50, 8'h10, 8'h10, 8'h01, 8'h00};
        vecs[1].exp = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        vecs[2].exp = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        vecs[4].exp = {8'hFF, 8'hFE, 8'hFE, 8'h81, 8'h80, 8'h02, 8'h02, 8'h00};
`else
        vecs[0].exp = {8'h00, 8'h01, 8'h10, 8'h10, 8'h50, 8'h7F, 8'h80, 8'hFF};
        vecs[1].exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[2].exp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[4].exp = {8'h00, 8'h02, 8'h02, 8'h80, 8'h81, 8'hFE, 8'hFE, 8'hFF};
`endif
        vecs[3].exp = {8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
        vecs[0].dly = 10;
        vecs[1].dly = 1;
        vecs[2].dly = 3;
        vecs[3].dly = 2;
        vecs[4].dly = 5;

        // Reset state
        repeat (3) @(negedge i_Clock);
        chk("reset tx_dv", 32'(o_Tx_DV), 32'd0);
        chk("reset tx_byte", 32'(o_Tx_Byte), 32'd0);
        chk("reset busy", 32'(o_Busy), 32'd0);
        chk("reset overrun", 32'(o_Overrun), 32'd0);
        i_Rst_n = 1'b1;
        @(negedge i_Clock);

        // Table of full batches
        for (int v = 0; v < 5; v++) begin
            send_batch(vecs[v].rx);
            wait_first_dv(1);
            drain(vecs[v].exp, 8, vecs[v].dly);
            chk("no overrun", 32'(o_Overrun), 32'd0);
            @(negedge i_Clock);
        end

        // Spurious done in COLLECT and SORT
        i_Tx_Done = 1'b1;
        @(negedge i_Clock);
        i_Tx_Done = 1'b0;
        chk("busy after stray done", 32'(o_Busy), 32'd0);
        send_batch(vecs[4].rx);
        @(negedge i_Clock);
        i_Tx_Done = 1'b1;
        @(negedge i_Clock);
        i_Tx_Done = 1'b0;
        wait_first_dv(3);
        drain(vecs[4].exp, 8, 2);

        // Overrun during SORT at N+5
        @(negedge i_Clock);
        send_batch(vecs[0].rx);
        repeat (4) @(negedge i_Clock);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = 8'hAA;
        @(negedge i_Clock);
        i_Rx_DV = 1'b0;
        chk("overrun at N+6", 32'(o_Overrun), 32'd1);
        wait_first_dv(6);
        drain(vecs[0].exp, 8, 4);
        chk("overrun sticky", 32'(o_Overrun), 32'd1);

        // Reset in WAIT_DONE after three bytes
        @(negedge i_Clock);
        send_batch(vecs[2].rx);
        wait_first_dv(1);
        drain(vecs[2].exp, 3, 4);
        @(negedge i_Clock);
        #2 i_Rst_n = 1'b0;
        #1;
        chk("async rst tx_dv", 32'(o_Tx_DV), 32'd0);
        chk("async rst tx_byte", 32'(o_Tx_Byte), 32'd0);
        chk("async rst busy", 32'(o_Busy), 32'd0);
        chk("async rst overrun", 32'(o_Overrun), 32'd0);
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        @(negedge i_Clock);

        // Partial batch discarded by reset
        for (int k = 0; k < 3; k++) begin
            i_Rx_DV   = 1'b1;
            i_Rx_Byte = 8'hEE;
            @(negedge i_Clock);
        end
        i_Rx_DV = 1'b0;
        #2 i_Rst_n = 1'b0;
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        @(negedge i_Clock);
        send_batch(vecs[2].rx);
        wait_first_dv(1);
        drain(vecs[2].exp, 8, 2);
        chk("overrun cleared by reset", 32'(o_Overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
